rifl_rx_gearbox: RTL

Parametrised receive-side upsizer. It repacks a stream of PAYLOAD_WIDTH-bit payload beats into FRAME_WIDTH-bit AXI-Stream beats, packed MSB-first and byte-exact. It sits between the RIFL frame de-encapsulation and the user RX AXIS port.
Compared with the fixed-ratio decoder it adds:
- any byte-granular width pair, with no requirement that FRAME_WIDTH be a multiple of FRAME_WIDTH-PAYLOAD_WIDTH;
- full tready backpressure on both sides;
- correct last-beat flushing when a flush spans multiple beats.

---
 rtl/rifl_rx_gearbox.sv | 117 +++++++++++
 1 files changed

// File: rtl/rifl_rx_gearbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rifl_rx_gearbox
//  Purpose  : Receive-side upsizer. Repacks PAYLOAD_WIDTH-bit payload beats
//             into FRAME_WIDTH-bit AXI-Stream beats, MSB-first, byte-exact,
//             with full backpressure and multi-beat end-of-packet flushing.
//  Revision : 1.0 - initial release
// ============================================================================
module rifl_rx_gearbox #(
   parameter int FRAME_WIDTH   = 256,
   parameter int PAYLOAD_WIDTH = 240
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [PAYLOAD_WIDTH-1:0]     s_axis_tdata,
   input  logic [PAYLOAD_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                         s_axis_tlast,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   output logic [FRAME_WIDTH-1:0]       m_axis_tdata,
   output logic [FRAME_WIDTH/8-1:0]     m_axis_tkeep,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready
);

   localparam int FWB       = FRAME_WIDTH / 8;
   localparam int PWB       = PAYLOAD_WIDTH / 8;
   localparam int ACC_BYTES = FWB + PWB;
   localparam int ACC_W     = ACC_BYTES * 8;
   localparam int CNT_W     = $clog2(ACC_BYTES + 1);
   localparam logic [CNT_W-1:0] FWB_C = CNT_W'(FWB);

   // Accumulator holds valid bytes left-justified; bytes below cnt are kept zero
   // so that new payload can simply be OR-ed in at the fill point.
   logic [ACC_W-1:0]          acc_q, acc_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      flush_q, flush_d;

   logic                      pop;
   logic                      push;
   logic                      cnt_full;
   logic [ACC_W-1:0]          acc_s;
   logic [CNT_W-1:0]          cnt_s;
   logic [ACC_W-1:0]          ins;
   logic [PWB-1:0]            keep_eff;
   logic [PAYLOAD_WIDTH-1:0]  data_m;
   logic [CNT_W-1:0]          keep_cnt;

   assign cnt_full      = (cnt_q >= FWB_C);
   assign m_axis_tvalid = cnt_full | flush_q;
   assign m_axis_tdata  = acc_q[ACC_W-1 -: FRAME_WIDTH];
   assign m_axis_tkeep  = cnt_full ? {FWB{1'b1}} : ~({FWB{1'b1}} >> cnt_q);
   assign m_axis_tlast  = flush_q & (cnt_q <= FWB_C);
   // Held low while reset is applied; after that, accept input unless a
   // flush is pending or the accumulator is full and the sink is stalled.
   assign s_axis_tready = rst_n & ~flush_q & (~cnt_full | m_axis_tready);

   assign pop  = m_axis_tvalid & m_axis_tready;
   assign push = s_axis_tvalid & s_axis_tready;

   // Zero the unkept bytes of the incoming beat and count the kept ones.
   always_comb begin
      keep_eff = s_axis_tlast ? s_axis_tkeep : {PWB{1'b1}};
      data_m   = '0;
      keep_cnt = '0;
      for (int i = 0; i < PWB; i++) begin
         if (keep_eff[i]) begin
            data_m[i*8 +: 8] = s_axis_tdata[i*8 +: 8];
            keep_cnt         = keep_cnt + CNT_W'(1);
         end
      end
   end

   // Next state: retire the popped beat first, then insert the pushed beat
   // right behind the remaining bytes.
   always_comb begin
      acc_s   = acc_q;
      cnt_s   = cnt_q;
      flush_d = flush_q;
      if (pop) begin
         acc_s = acc_q << FRAME_WIDTH;
         if (m_axis_tlast) begin
            cnt_s   = '0;
            flush_d = 1'b0;
         end else begin
            cnt_s = cnt_full ? (cnt_q - FWB_C) : '0;
         end
      end
      ins   = {data_m, {FRAME_WIDTH{1'b0}}} >> {cnt_s, 3'b000};
      acc_d = acc_s;
      cnt_d = cnt_s;
      if (push) begin
         acc_d = acc_s | ins;
         cnt_d = cnt_s + keep_cnt;
         if (s_axis_tlast) begin
            flush_d = 1'b1;
         end
      end
   end

   // State registers; reset discards any partially assembled data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         flush_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
      end
   end

endmodule
`default_nettype wire
